// File: rtl/filter_pkg.sv
// Shared definitions for the filter controller: coefficient/sample widths,
// staging depth and the sequencer state encoding.
package filter_pkg;

  localparam int NCOEF    = 12;
  localparam int COEF_W   = 10;
  localparam int SAMPLE_W = 16;
  localparam int IDX_W    = $clog2(NCOEF);

  typedef logic [COEF_W-1:0]   coef_t;
  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [IDX_W-1:0]    idx_t;

  localparam idx_t LAST_IDX = idx_t'(NCOEF - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    START,
    GUARD,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/coef_stage.sv
// Coefficient staging buffer: 12 sign-magnitude entries filled in order,
// refusing writes once full, rewound by the controller after a transfer.
module coef_stage
  import filter_pkg::*;
(
  input  logic  clk,
  input  logic  rst_an,
  input  logic  wr,
  input  coef_t wr_data,
  input  logic  flush,
  input  idx_t  rd_idx,
  output coef_t rd_data,
  output logic  full
);

  coef_t mem [NCOEF];
  idx_t  wr_ptr;

  // Pointer stays on the last slot once full; flush rewinds it and reopens the buffer.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      wr_ptr <= '0;
      full   <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      full   <= 1'b0;
    end else if (wr && !full) begin
      mem[wr_ptr] <= wr_data;
      if (wr_ptr == LAST_IDX) begin
        full <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + idx_t'(1);
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/filter_ctrl.sv
// Filter controller: sequences coefficient transfer, state clear, start and
// completion wait for an external filter once per accepted sample tick.
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int TIMEOUT = 511
) (
  input  logic                clk,
  input  logic                rst_an,
  input  logic [COEF_W-1:0]   coef_wr_data,
  input  logic                coef_wr,
  input  logic                frame_commit,
  input  logic                frame_clear,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] src_in,
  input  logic                flt_done,
  input  logic [SAMPLE_W-1:0] flt_out,
  output logic [COEF_W-1:0]   flt_coef,
  output logic                flt_coef_load,
  output logic                flt_clear_states,
  output logic [SAMPLE_W-1:0] flt_sig_in,
  output logic                flt_start,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                stage_full,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, next_state;
  idx_t             load_idx, rd_idx;
  logic [CNT_W-1:0] wait_cnt;
  logic             commit_pending, clear_pending;
  logic             tick_ok, load_last, timeout_hit, stage_wr;
  coef_t            rd_data, coef_nxt;
  logic             coef_load_nxt, clear_nxt, start_nxt, valid_nxt;

  // A tick is only taken when idle and the filter reports done; anything else is dropped.
  assign tick_ok     = sample_tick && flt_done && (state == IDLE);
  assign load_last   = (state == LOAD) && (load_idx == LAST_IDX);
  assign timeout_hit = (state == WAIT) && !flt_done && (wait_cnt == WAIT_LAST);
  assign stage_wr    = coef_wr && (state != LOAD);
  assign rd_idx      = ((state == LOAD) && !load_last) ? load_idx + idx_t'(1) : '0;

  coef_stage u_stage (
    .clk     (clk),
    .rst_an  (rst_an),
    .wr      (stage_wr),
    .wr_data (coef_wr_data),
    .flush   (load_last),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .full    (stage_full)
  );

  // Next-state decode for the per-sample sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (tick_ok) begin
          if (commit_pending)     next_state = LOAD;
          else if (clear_pending) next_state = CLEAR;
          else                    next_state = START;
        end
      end
      LOAD:    if (load_last) next_state = clear_pending ? CLEAR : START;
      CLEAR:   next_state = START;
      START:   next_state = GUARD;
      GUARD:   next_state = WAIT;
      WAIT: begin
        if (flt_done)         next_state = OUT;
        else if (timeout_hit) next_state = IDLE;
      end
      OUT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobe values for the coming cycle, registered below so the filter sees clean edges.
  always_comb begin
    coef_load_nxt = (next_state == LOAD);
    coef_nxt      = coef_load_nxt ? rd_data : '0;
    clear_nxt     = (next_state == CLEAR) || timeout_hit;
    start_nxt     = (next_state == START);
    valid_nxt     = (next_state == OUT);
  end

  // State, registered strobes, counters, pending requests and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      state            <= IDLE;
      load_idx         <= '0;
      wait_cnt         <= '0;
      commit_pending   <= 1'b0;
      clear_pending    <= 1'b0;
      overrun          <= 1'b0;
      timeout_err      <= 1'b0;
      flt_coef         <= '0;
      flt_coef_load    <= 1'b0;
      flt_clear_states <= 1'b0;
      flt_start        <= 1'b0;
      sample_valid     <= 1'b0;
      sample_out       <= '0;
      flt_sig_in       <= '0;
    end else begin
      state            <= next_state;
      flt_coef         <= coef_nxt;
      flt_coef_load    <= coef_load_nxt;
      flt_clear_states <= clear_nxt;
      flt_start        <= start_nxt;
      sample_valid     <= valid_nxt;
      if (tick_ok)   flt_sig_in <= src_in;
      if (valid_nxt) sample_out <= flt_out;
      load_idx <= ((state == LOAD) && !load_last) ? load_idx + idx_t'(1) : '0;
      wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
      if (sample_tick && !tick_ok) overrun <= 1'b1;
      if (timeout_hit)             timeout_err <= 1'b1;
      if (load_last)                        commit_pending <= 1'b0;
      else if (frame_commit && stage_full)  commit_pending <= 1'b1;
      if (frame_clear)         clear_pending <= 1'b1;
      else if (state == CLEAR) clear_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filter_ctrl.sv
// Self-checking bench for filter_ctrl: a behavioural filter answers flt_start,
// a scoreboard queue holds expected samples, and directed sequences cover
// coefficient transfer, clear, overrun, timeout and reset abort.
module tb_filter_ctrl;
  import filter_pkg::*;

  localparam int TIMEOUT = 511;

  typedef struct {
    logic [15:0] src;
    int          delay;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_an = 1'b0;
  logic [9:0]  coef_wr_data = '0;
  logic        coef_wr = 1'b0;
  logic        frame_commit = 1'b0;
  logic        frame_clear = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] src_in = '0;
  logic        flt_done = 1'b1;
  logic [15:0] flt_out = '0;
  logic [9:0]  flt_coef;
  logic        flt_coef_load;
  logic        flt_clear_states;
  logic [15:0] flt_sig_in;
  logic        flt_start;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        stage_full;
  logic        overrun;
  logic        timeout_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          valid_cnt = 0;
  int          dly = 0;
  int          busy = 0;
  logic        hang = 1'b0;
  logic [15:0] exp_q [$];
  vec_t        vecs [5];

  filter_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst_an           (rst_an),
    .coef_wr_data     (coef_wr_data),
    .coef_wr          (coef_wr),
    .frame_commit     (frame_commit),
    .frame_clear      (frame_clear),
    .sample_tick      (sample_tick),
    .src_in           (src_in),
    .flt_done         (flt_done),
    .flt_out          (flt_out),
    .flt_coef         (flt_coef),
    .flt_coef_load    (flt_coef_load),
    .flt_clear_states (flt_clear_states),
    .flt_sig_in       (flt_sig_in),
    .flt_start        (flt_start),
    .sample_out       (sample_out),
    .sample_valid     (sample_valid),
    .stage_full       (stage_full),
    .overrun          (overrun),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Filter model: goes busy on flt_start, finishes after dly cycles with the inverted input.
  always @(negedge clk) begin
    if (flt_start) begin
      flt_done = 1'b0;
      busy     = dly;
    end else if (!flt_done && !hang) begin
      if (busy == 0) begin
        flt_done = 1'b1;
        flt_out  = ~flt_sig_in;
      end else begin
        busy = busy - 1;
      end
    end
  end

  // Scoreboard: every sample_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_an && sample_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("sb_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        checkOutput("sample_out", sample_out, exp_q.pop_front());
      end
    end
  end

  // Watchdog in case a wait is ever left unbounded.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic doReset();
    @(negedge clk);
    rst_an = 1'b0;
    repeat (2) @(negedge clk);
    rst_an = 1'b1;
    exp_q.delete();
  endtask

  task automatic driveTick(input logic [15:0] s);
    @(negedge clk);
    sample_tick = 1'b1;
    src_in      = s;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic writeCoef(input logic [9:0] d, input logic with_commit);
    @(negedge clk);
    coef_wr      = 1'b1;
    coef_wr_data = d;
    frame_commit = with_commit;
    @(negedge clk);
    coef_wr      = 1'b0;
    frame_commit = 1'b0;
  endtask

  task automatic pulseCommit();
    @(negedge clk);
    frame_commit = 1'b1;
    @(negedge clk);
    frame_commit = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    frame_clear = 1'b1;
    @(negedge clk);
    frame_clear = 1'b0;
  endtask

  task automatic waitValid(input int c0, input int budget, input string tag);
    int n = 0;
    while (valid_cnt == c0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_valid_count"}, 32'(valid_cnt - c0), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_coef"},        flt_coef,         '0);
    checkOutput({tag, "_coef_load"},   flt_coef_load,    '0);
    checkOutput({tag, "_clear"},       flt_clear_states, '0);
    checkOutput({tag, "_sig_in"},      flt_sig_in,       '0);
    checkOutput({tag, "_start"},       flt_start,        '0);
    checkOutput({tag, "_sample_out"},  sample_out,       '0);
    checkOutput({tag, "_valid"},       sample_valid,     '0);
    checkOutput({tag, "_stage_full"},  stage_full,       '0);
    checkOutput({tag, "_overrun"},     overrun,          '0);
    checkOutput({tag, "_timeout_err"}, timeout_err,      '0);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int c0;
    dly = v.delay;
    exp_q.push_back(v.exp);
    c0 = valid_cnt;
    driveTick(v.src);
    checkOutput({tag, "_start"},  flt_start,  32'd1);
    checkOutput({tag, "_sig_in"}, flt_sig_in, v.src);
    waitValid(c0, v.delay + 20, tag);
  endtask

  initial begin
    int c0;
    int first_err;
    int clr_cnt;
    int bad_cnt;

    vecs[0] = '{src: 16'h1234, delay: 0,  exp: 16'hEDCB};
    vecs[1] = '{src: 16'h8000, delay: 3,  exp: 16'h7FFF};
    vecs[2] = '{src: 16'h0000, delay: 7,  exp: 16'hFFFF};
    vecs[3] = '{src: 16'hFFFF, delay: 1,  exp: 16'h0000};
    vecs[4] = '{src: 16'h00F0, delay: 20, exp: 16'hFF0F};

    // Reset state
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_an = 1'b1;

    // Plain samples, no commit or clear pending
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end
    checkOutput("vec_no_overrun", overrun, 32'd0);

    // Full coefficient transfer; a 13th write on a full buffer is ignored
    doReset();
    for (int i = 1; i <= 12; i++) writeCoef(10'(i), 1'b0);
    checkOutput("full_after_12", stage_full, 32'd1);
    writeCoef(10'h3FF, 1'b0);
    pulseCommit();
    dly = 2;
    exp_q.push_back(16'hF0F0);
    c0 = valid_cnt;
    driveTick(16'h0F0F);
    checkOutput("load0_strobe", flt_coef_load, 32'd1);
    checkOutput("load0_coef",   flt_coef,      32'd1);
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("load%0d_strobe", k), flt_coef_load, 32'd1);
      checkOutput($sformatf("load%0d_coef", k),   flt_coef,      32'(k + 1));
    end
    @(negedge clk);
    checkOutput("load_end_strobe", flt_coef_load, 32'd0);
    checkOutput("load_end_start",  flt_start,     32'd1);
    checkOutput("load_end_full",   stage_full,    32'd0);
    waitValid(c0, 30, "load");

    // Commit with only 5 entries is ignored
    doReset();
    for (int i = 1; i <= 5; i++) writeCoef(10'(i), 1'b0);
    pulseCommit();
    checkOutput("partial_full", stage_full, 32'd0);
    dly = 1;
    exp_q.push_back(16'h8001);
    c0 = valid_cnt;
    driveTick(16'h7FFE);
    checkOutput("partial_start", flt_start,     32'd1);
    checkOutput("partial_load",  flt_coef_load, 32'd0);
    waitValid(c0, 30, "partial");

    // Commit in the same cycle as the filling write sees the old, not-full flag
    for (int i = 6; i <= 11; i++) writeCoef(10'(i), 1'b0);
    writeCoef(10'd12, 1'b1);
    checkOutput("samecyc_full", stage_full, 32'd1);
    exp_q.push_back(16'hBEEF);
    c0 = valid_cnt;
    driveTick(16'h4110);
    checkOutput("samecyc_start", flt_start,     32'd1);
    checkOutput("samecyc_load",  flt_coef_load, 32'd0);
    waitValid(c0, 30, "samecyc");
    pulseCommit();
    exp_q.push_back(16'hA55A);
    c0 = valid_cnt;
    driveTick(16'h5AA5);
    checkOutput("recommit_load", flt_coef_load, 32'd1);
    checkOutput("recommit_coef", flt_coef,      32'd1);
    waitValid(c0, 40, "recommit");

    // Pending clear: one clear cycle, then start with the held sample
    doReset();
    pulseClear();
    dly = 0;
    exp_q.push_back(16'hEFFF);
    c0 = valid_cnt;
    driveTick(16'h1000);
    checkOutput("clr_pulse",       flt_clear_states, 32'd1);
    checkOutput("clr_no_start",    flt_start,        32'd0);
    @(negedge clk);
    checkOutput("clr_pulse_end",   flt_clear_states, 32'd0);
    checkOutput("clr_start",       flt_start,        32'd1);
    checkOutput("clr_sig_in",      flt_sig_in,       32'h1000);
    waitValid(c0, 30, "clr");

    // Tick while waiting on the filter is dropped and flagged
    doReset();
    dly = 30;
    exp_q.push_back(16'hDDDD);
    c0 = valid_cnt;
    driveTick(16'h2222);
    repeat (5) @(negedge clk);
    driveTick(16'h3333);
    checkOutput("ovr_flag",   overrun,    32'd1);
    checkOutput("ovr_sig_in", flt_sig_in, 32'h2222);
    waitValid(c0, 60, "ovr");
    repeat (40) @(negedge clk);
    checkOutput("ovr_single_valid", 32'(valid_cnt - c0), 32'd1);

    // Filter never finishes: error after TIMEOUT wait cycles (sample index
    // TIMEOUT+2 counting the START cycle as 0), one clear pulse, no sample
    doReset();
    hang = 1'b1;
    dly  = 0;
    c0   = valid_cnt;
    first_err = -1;
    clr_cnt   = 0;
    driveTick(16'h4444);
    checkOutput("to_start", flt_start, 32'd1);
    for (int n = 1; n <= TIMEOUT + 8; n++) begin
      @(negedge clk);
      if (flt_clear_states) clr_cnt++;
      if (timeout_err && first_err < 0) first_err = n;
    end
    checkOutput("to_cycle",       32'(first_err),       32'(TIMEOUT + 2));
    checkOutput("to_clear_count", 32'(clr_cnt),         32'd1);
    checkOutput("to_no_valid",    32'(valid_cnt - c0),  32'd0);
    hang = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus('{src: 16'h5555, delay: 0, exp: 16'hAAAA}, "post_to");
    checkOutput("to_sticky", timeout_err, 32'd1);

    // Reset during LOAD entry 6 aborts the transfer and clears the sticky flag
    for (int i = 1; i <= 12; i++) writeCoef(10'(i), 1'b0);
    pulseCommit();
    driveTick(16'h6666);
    repeat (6) @(negedge clk);
    checkOutput("abort_at_entry6", flt_coef, 32'd7);
    rst_an = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    rst_an  = 1'b1;
    bad_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (flt_coef_load || flt_start) bad_cnt++;
    end
    checkOutput("abort_no_strobes", 32'(bad_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
